// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: FETCH/DECODE/EXEC/MEM FSM sequencing the RV64I datapath, with instret and timeout halt
module multicycle_control_unit #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_WIDTH   = 64
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic [6:0]           opcode,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 WE_RF,
    output logic                 WE_MEM,
    output logic [1:0]           RF_din_sel,
    output logic                 ULA_din2_sel,
    output logic                 addr_sel,
    output logic                 load_pc,
    output logic                 load_ir,
    output logic                 pc_next_sel,
    output logic                 pc_adder_sel,
    output logic                 halted,
    output logic [1:0]           halt_cause,
    output logic [CNT_WIDTH-1:0] instret
);
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM_RD, S_MEM_WR, S_HALT} state_t;
    typedef enum logic [2:0] {C_R, C_I, C_AUIPC, C_JAL, C_JALR, C_BR} cls_t;

    state_t               state_q, state_d;
    cls_t                 cls_q, cls_d;
    logic [1:0]           cause_q, cause_d;
    logic [7:0]           wait_q, wait_d;
    logic [CNT_WIDTH-1:0] instret_q, instret_d;
    logic                 tmo, retire;

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q   <= S_FETCH;
            cls_q     <= C_R;
            cause_q   <= 2'b00;
            wait_q    <= 8'd0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            cause_q   <= cause_d;
            wait_q    <= wait_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        cause_d = cause_q;
        wait_d  = 8'd0;
        tmo     = !mem_ready && wait_q == 8'(MEM_TIMEOUT);
        retire  = state_q == S_EXEC || ((state_q == S_MEM_RD || state_q == S_MEM_WR) && mem_ready);
        case (state_q)
            S_FETCH, S_MEM_RD, S_MEM_WR: begin
                state_d = mem_ready ? (state_q == S_FETCH ? S_DECODE : S_FETCH) : tmo ? S_HALT : state_q;
                cause_d = tmo ? 2'b10 : cause_q;
                wait_d  = (!mem_ready && !tmo) ? wait_q + 8'd1 : 8'd0;
            end
            S_DECODE: begin
                state_d = S_EXEC;
                case (opcode)
                    7'b0110011, 7'b0111011:             cls_d = C_R;
                    7'b0010011, 7'b0011011, 7'b0110111: cls_d = C_I;
                    7'b0010111:                         cls_d = C_AUIPC;
                    7'b1101111:                         cls_d = C_JAL;
                    7'b1100111:                         cls_d = C_JALR;
                    7'b1100011:                         cls_d = C_BR;
                    7'b0000011:                         state_d = S_MEM_RD;
                    7'b0100011:                         state_d = S_MEM_WR;
                    default: begin
                        state_d = S_HALT;
                        cause_d = 2'b01;
                    end
                endcase
            end
            S_EXEC:  state_d = S_FETCH;
            default: state_d = S_HALT;
        endcase
        instret_d = instret_q + {{(CNT_WIDTH-1){1'b0}}, retire};
    end

    // Every output is forced low while reset is held, aborting any in-flight write.
    logic st_fetch, st_exec, st_rd, st_wr;
    always_comb begin
        st_fetch     = !reset && state_q == S_FETCH;
        st_exec      = !reset && state_q == S_EXEC;
        st_rd        = !reset && state_q == S_MEM_RD;
        st_wr        = !reset && state_q == S_MEM_WR;
        mem_req      = st_fetch || st_rd || st_wr;
        addr_sel     = st_fetch;
        load_ir      = st_fetch && mem_ready;
        WE_RF        = (st_exec && cls_q != C_BR) || (st_rd && mem_ready);
        WE_MEM       = st_wr && mem_ready;
        load_pc      = st_exec || ((st_rd || st_wr) && mem_ready);
        RF_din_sel   = !st_exec ? 2'b00 :
                       (cls_q == C_R || cls_q == C_I) ? 2'b01 :
                       cls_q == C_AUIPC ? 2'b11 :
                       (cls_q == C_JAL || cls_q == C_JALR) ? 2'b10 : 2'b00;
        ULA_din2_sel = (st_exec && (cls_q == C_I || cls_q == C_JALR)) || st_rd || st_wr;
        pc_next_sel  = st_exec && (cls_q == C_JAL || cls_q == C_JALR || cls_q == C_BR);
        pc_adder_sel = st_exec && cls_q == C_JALR;
        halted       = !reset && state_q == S_HALT;
        halt_cause   = reset ? 2'b00 : cause_q;
        instret      = reset ? '0 : instret_q;
    end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: table-driven cycle vectors plus a timeout sequence
module tb_multicycle_control_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  opcode = 7'h00;
    logic        mem_ready = 1'b0;
    logic        mem_req, WE_RF, WE_MEM, ULA_din2_sel, addr_sel, load_pc, load_ir;
    logic        pc_next_sel, pc_adder_sel, halted;
    logic [1:0]  RF_din_sel, halt_cause;
    logic [63:0] instret;

    always #5 clk = ~clk;

    multicycle_control_unit #(.MEM_TIMEOUT(4), .CNT_WIDTH(64)) dut (
        .CLK(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .mem_req(mem_req), .WE_RF(WE_RF), .WE_MEM(WE_MEM), .RF_din_sel(RF_din_sel),
        .ULA_din2_sel(ULA_din2_sel), .addr_sel(addr_sel), .load_pc(load_pc),
        .load_ir(load_ir), .pc_next_sel(pc_next_sel), .pc_adder_sel(pc_adder_sel),
        .halted(halted), .halt_cause(halt_cause), .instret(instret)
    );

    typedef struct {
        logic        rst;
        logic [6:0]  op;
        logic        rdy;
        logic [13:0] exp;
        logic [63:0] cnt;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // {mem_req, WE_RF, WE_MEM, RF_din_sel, ULA_din2_sel, addr_sel, load_pc, load_ir, pc_next_sel, pc_adder_sel, halted, halt_cause}
    function automatic logic [13:0] o(logic mr, logic wr, logic wm, logic [1:0] rf, logic u2,
                                      logic as, logic lp, logic li, logic pn, logic pa,
                                      logic h, logic [1:0] c);
        return {mr, wr, wm, rf, u2, as, lp, li, pn, pa, h, c};
    endfunction

    function automatic logic [13:0] ex(logic wr, logic [1:0] rf, logic u2, logic pn, logic pa);
        return o(1'b0, wr, 1'b0, rf, u2, 1'b0, 1'b1, 1'b0, pn, pa, 1'b0, 2'b00);
    endfunction

    task automatic add(logic rst, logic [6:0] op, logic rdy, logic [13:0] exp, logic [63:0] cnt);
        vec_t v;
        v.rst = rst; v.op = op; v.rdy = rdy; v.exp = exp; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    function automatic logic [13:0] outs();
        return {mem_req, WE_RF, WE_MEM, RF_din_sel, ULA_din2_sel, addr_sel, load_pc,
                load_ir, pc_next_sel, pc_adder_sel, halted, halt_cause};
    endfunction

    // 3-cycle instruction: fetch, decode, exec; exec_op lets EXEC see a garbage opcode
    task automatic add_alu(logic [6:0] op, logic [6:0] exec_op, logic [13:0] exec_exp, logic [63:0] cnt);
        add(0, op, 1, F1, cnt);
        add(0, op, 1, 14'd0, cnt);
        add(0, exec_op, 1, exec_exp, cnt);
    endtask

    logic [13:0] F1, F0, MW, RDR, WRR, H1;

    initial begin
        int fetch_cycles;
        bit seen;
        F1  = o(1, 0, 0, 2'b00, 0, 1, 0, 1, 0, 0, 0, 2'b00);
        F0  = o(1, 0, 0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 2'b00);
        MW  = o(1, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 2'b00);
        RDR = o(1, 1, 0, 2'b00, 1, 0, 1, 0, 0, 0, 0, 2'b00);
        WRR = o(1, 0, 1, 2'b00, 1, 0, 1, 0, 0, 0, 0, 2'b00);
        H1  = o(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 2'b01);
        add(1, 7'h00, 1, 14'd0, 0);
        add(1, 7'h00, 1, 14'd0, 0);
        add_alu(7'h13, 7'h13, ex(1, 2'b01, 1, 0, 0), 0);
        add_alu(7'h33, 7'h33, ex(1, 2'b01, 0, 0, 0), 1);
        add_alu(7'h37, 7'h37, ex(1, 2'b01, 1, 0, 0), 2);
        add_alu(7'h17, 7'h7F, ex(1, 2'b11, 0, 0, 0), 3);
        add_alu(7'h6F, 7'h6F, ex(1, 2'b10, 0, 1, 0), 4);
        add_alu(7'h67, 7'h67, ex(1, 2'b10, 1, 1, 1), 5);
        add_alu(7'h63, 7'h63, ex(0, 2'b00, 0, 1, 0), 6);
        add_alu(7'h1B, 7'h1B, ex(1, 2'b01, 1, 0, 0), 7);
        add(0, 7'h03, 1, F1, 8);
        add(0, 7'h03, 1, 14'd0, 8);
        add(0, 7'h03, 0, MW, 8);
        add(0, 7'h03, 0, MW, 8);
        add(0, 7'h03, 0, MW, 8);
        add(0, 7'h03, 1, RDR, 8);
        add(0, 7'h23, 1, F1, 9);
        add(0, 7'h23, 1, 14'd0, 9);
        add(0, 7'h23, 0, MW, 9);
        add(0, 7'h23, 1, WRR, 9);
        add(0, 7'h67, 1, F1, 10);
        add(0, 7'h67, 1, 14'd0, 10);
        add(1, 7'h67, 1, 14'd0, 0);
        add_alu(7'h13, 7'h13, ex(1, 2'b01, 1, 0, 0), 0);
        add(0, 7'h7F, 1, F1, 1);
        add(0, 7'h7F, 1, 14'd0, 1);
        add(0, 7'h7F, 1, H1, 1);
        add(0, 7'h13, 0, H1, 1);
        add(1, 7'h00, 0, 14'd0, 0);
        add(0, 7'h13, 0, F0, 0);
        add(0, 7'h13, 0, F0, 0);
        add(0, 7'h13, 0, F0, 0);
        add(0, 7'h13, 0, F0, 0);
        add_alu(7'h13, 7'h13, ex(1, 2'b01, 1, 0, 0), 0);
        add(0, 7'h13, 1, F1, 1);
        foreach (vecs[i]) begin
            @(negedge clk);
            reset = vecs[i].rst; opcode = vecs[i].op; mem_ready = vecs[i].rdy;
            #1;
            n_cmp++;
            if (outs() !== vecs[i].exp) begin
                n_bad++;
                $display("FAIL row%0d strobes got %b want %b", i, outs(), vecs[i].exp);
            end
            n_cmp++;
            if (instret !== vecs[i].cnt) begin
                n_bad++;
                $display("FAIL row%0d instret got %0d want %0d", i, instret, vecs[i].cnt);
            end
        end
        // memory never answers in FETCH: expect 5 fetch cycles then HALT with cause 10
        @(negedge clk);
        reset = 1'b1; mem_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        fetch_cycles = 0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            #1;
            if (halted) seen = 1;
            else if (mem_req && addr_sel) fetch_cycles++;
            if (!seen) @(negedge clk);
        end
        n_cmp++;
        if (!seen || fetch_cycles != 5) begin
            n_bad++;
            $display("FAIL timeout_cycles got %0d halted=%0b want 5 halted=1", fetch_cycles, seen);
        end
        n_cmp++;
        if (halt_cause !== 2'b10 || mem_req !== 1'b0 || addr_sel !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_state got cause=%b mem_req=%b want cause=10 mem_req=0", halt_cause, mem_req);
        end
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        n_cmp++;
        if (!halted || halt_cause !== 2'b10 || instret !== 64'd0) begin
            n_bad++;
            $display("FAIL halt_sticky got halted=%b cause=%b instret=%0d want 1 10 0", halted, halt_cause, instret);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
